// File: rtl/matriz_max7219_tx.sv
// matriz_max7219_tx: serialises an 8-row LED matrix frame into MAX7219
// register writes. Each transfer is a 16-bit word {4'h0, addr, data}, sent MSB first.
// Optional build macro MATRIZ_TX_INIT_EN adds the MAX7219 power-up init
// sequence. The block sends that sequence after every reset and holds off refresh
// requests until the sequence has finished.
module matriz_max7219_tx #(
  parameter int         DATAWIDTH = 8,
  parameter int         CLKDIV    = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic                 MatrizTx_CLOCK_50,
  input  logic                 MatrizTx_RESET_InLow,
  input  logic                 MatrizTx_Start_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila1_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila2_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila3_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila4_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila5_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila6_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila7_In,
  input  logic [DATAWIDTH-1:0] MatrizTx_Fila8_In,
  output logic                 MatrizTx_Busy_Out,
  output logic                 MatrizTx_Done_Out,
  output logic                 MatrizTx_CS_Out,
  output logic                 MatrizTx_SCLK_Out,
  output logic                 MatrizTx_DIN_Out
);

  localparam int         MAXW     = (DATAWIDTH > 8) ? DATAWIDTH : 8;
  localparam logic [8:0] HALF     = 9'(CLKDIV);
  localparam logic [8:0] BIT_LAST = 9'(2 * CLKDIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(CLKDIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, NEXT} state_t;

  state_t      state, state_nxt;
  logic [8:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [2:0]  widx;
  logic [15:0] shreg;
  logic [15:0] word_sel;
  logic [7:0]  row_q [8];
  logic [7:0]  rows_in [8];
  logic        done_q;
  logic        init_mode;
  logic        start_go;
  logic        init_go;
  logic        last_div;
  logic        words_left;

  // Rows wider than a byte keep only bits [7:0]; narrower rows are zero-extended
  function automatic logic [7:0] to_byte(input logic [DATAWIDTH-1:0] r);
    logic [MAXW-1:0] ext;
    ext = '0;
    ext[DATAWIDTH-1:0] = r;
    return ext[7:0];
  endfunction

  assign rows_in[0] = to_byte(MatrizTx_Fila1_In);
  assign rows_in[1] = to_byte(MatrizTx_Fila2_In);
  assign rows_in[2] = to_byte(MatrizTx_Fila3_In);
  assign rows_in[3] = to_byte(MatrizTx_Fila4_In);
  assign rows_in[4] = to_byte(MatrizTx_Fila5_In);
  assign rows_in[5] = to_byte(MatrizTx_Fila6_In);
  assign rows_in[6] = to_byte(MatrizTx_Fila7_In);
  assign rows_in[7] = to_byte(MatrizTx_Fila8_In);

`ifdef MATRIZ_TX_INIT_EN
  logic init_pend;

  assign init_go  = (state == IDLE) && init_pend;
  assign start_go = (state == IDLE) && !init_pend && MatrizTx_Start_In;

  // Init is owed after every reset; init_mode marks the sequence in flight
  always_ff @(posedge MatrizTx_CLOCK_50 or negedge MatrizTx_RESET_InLow) begin
    if (!MatrizTx_RESET_InLow) begin
      init_pend <= 1'b1;
      init_mode <= 1'b0;
    end else if (init_go) begin
      init_pend <= 1'b0;
      init_mode <= 1'b1;
    end else if (start_go) begin
      init_mode <= 1'b0;
    end
  end
`else
  assign init_go   = 1'b0;
  assign init_mode = 1'b0;
  assign start_go  = (state == IDLE) && MatrizTx_Start_In;
`endif

  assign last_div   = (div_cnt == BIT_LAST);
  assign words_left = init_mode ? (widx != 3'd4) : (widx != 3'd7);

  // Word for the current slot: init table entry or row address/data pair
  always_comb begin
    word_sel = {4'h0, 4'({1'b0, widx}) + 4'd1, row_q[widx]};
`ifdef MATRIZ_TX_INIT_EN
    if (init_mode) begin
      case (widx)
        3'd0:    word_sel = 16'h0C01;
        3'd1:    word_sel = 16'h0900;
        3'd2:    word_sel = 16'h0B07;
        3'd3:    word_sel = {12'h0A0, INTENSITY};
        default: word_sel = 16'h0F00;
      endcase
    end
`endif
  end

  // State register
  always_ff @(posedge MatrizTx_CLOCK_50 or negedge MatrizTx_RESET_InLow) begin
    if (!MatrizTx_RESET_InLow) state <= IDLE;
    else                       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (init_go || start_go) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (last_div && (bit_cnt == 4'd15)) state_nxt = GAP;
      GAP:   if (div_cnt == GAP_LAST) state_nxt = NEXT;
      NEXT:  state_nxt = words_left ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, shift register, word index, row snapshot and done pulse
  always_ff @(posedge MatrizTx_CLOCK_50 or negedge MatrizTx_RESET_InLow) begin
    if (!MatrizTx_RESET_InLow) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      widx    <= '0;
      shreg   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) row_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          widx    <= '0;
          if (start_go) begin
            for (int i = 0; i < 8; i++) row_q[i] <= rows_in[i];
          end
        end
        LOAD: begin
          shreg   <= word_sel;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (last_div) begin
            div_cnt <= '0;
            shreg   <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            div_cnt <= div_cnt + 9'd1;
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) div_cnt <= '0;
          else                     div_cnt <= div_cnt + 9'd1;
        end
        NEXT: begin
          div_cnt <= '0;
          if (words_left) widx   <= widx + 3'd1;
          else            done_q <= !init_mode;
        end
        default: div_cnt <= '0;
      endcase
    end
  end

  // Serial outputs decoded from state: CS low across LOAD and SHIFT, SCLK high in second half of each bit
  always_comb begin
    MatrizTx_Busy_Out = (state != IDLE);
    MatrizTx_Done_Out = done_q;
    MatrizTx_CS_Out   = !((state == LOAD) || (state == SHIFT));
    MatrizTx_SCLK_Out = (state == SHIFT) && (div_cnt >= HALF);
    MatrizTx_DIN_Out  = (state == SHIFT) && shreg[15];
  end

endmodule

// File: tb/tb_matriz_max7219_tx.sv
// Testbench for matriz_max7219_tx: scoreboard of expected 16-bit words fed by
// the stimulus, checked by an SPI-decoding monitor; frame timing checked inline.
module tb_matriz_max7219_tx;

  localparam int CLKDIV = 2;
  localparam int FRAME  = 8 * (32 * CLKDIV + 1 + CLKDIV) + 8;
  localparam int WORD   = 33 * CLKDIV + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] fila [8];
  logic       busy, done, cs, sclk, din;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  matriz_max7219_tx #(.DATAWIDTH(8), .CLKDIV(CLKDIV), .INTENSITY(4'h8)) dut (
    .MatrizTx_CLOCK_50   (clk),
    .MatrizTx_RESET_InLow(rst_n),
    .MatrizTx_Start_In   (start),
    .MatrizTx_Fila1_In   (fila[0]),
    .MatrizTx_Fila2_In   (fila[1]),
    .MatrizTx_Fila3_In   (fila[2]),
    .MatrizTx_Fila4_In   (fila[3]),
    .MatrizTx_Fila5_In   (fila[4]),
    .MatrizTx_Fila6_In   (fila[5]),
    .MatrizTx_Fila7_In   (fila[6]),
    .MatrizTx_Fila8_In   (fila[7]),
    .MatrizTx_Busy_Out   (busy),
    .MatrizTx_Done_Out   (done),
    .MatrizTx_CS_Out     (cs),
    .MatrizTx_SCLK_Out   (sclk),
    .MatrizTx_DIN_Out    (din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push_frame(input logic [7:0] r [8]);
    for (int i = 0; i < 8; i++) exp_q.push_back({4'h0, 4'(i + 1), r[i]});
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C01);
    exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0B07);
    exp_q.push_back(16'h0A08);
    exp_q.push_back(16'h0F00);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) chk("idle timeout", {31'd0, busy}, 32'd0);
  endtask

  // Counts edges after the accepting edge until Done is seen; optionally drops Start
  task automatic time_frame(input int drop_at, output int n);
    n = 0;
    while (!done && n < FRAME + 50) begin
      @(posedge clk); #1;
      n++;
      if (n == drop_at) start = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic after_reset_release();
    @(negedge clk) rst_n = 1'b1;
`ifdef MATRIZ_TX_INIT_EN
    push_init();
    @(posedge clk); #1;
    chk("init busy after release", {31'd0, busy}, 32'd1);
    wait_idle(6 * WORD);
`else
    repeat (2) @(posedge clk);
    #1;
    chk("idle after release", {31'd0, busy}, 32'd0);
`endif
  endtask

  // Monitor: decode each CS-low window into a word and compare against the scoreboard
  logic        in_win = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [15:0] sh = '0;
  int          bits = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_win    = 1'b0;
      bits      = 0;
      prev_sclk = 1'b0;
    end else begin
      if (!cs) begin
        if (!in_win) begin
          in_win = 1'b1;
          bits   = 0;
          sh     = '0;
        end
        if (sclk && !prev_sclk) begin
          sh = {sh[14:0], din};
          bits++;
        end
      end else if (in_win) begin
        in_win = 1'b0;
        chk("bits per word", bits, 16);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious word: got %04h, expected no word", sh);
        end else begin
          chk("word", {16'd0, sh}, {16'd0, exp_q.pop_front()});
        end
      end
      prev_sclk = sclk;
      if (done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0, falls;
    logic pcs;
    for (int i = 0; i < 8; i++) fila[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset cs",   {31'd0, cs},   32'd1);
    chk("reset sclk", {31'd0, sclk}, 32'd0);
    chk("reset din",  {31'd0, din},  32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    after_reset_release();
    chk("no done for init", done_cnt, 0);

    // Frame with Fila1=0x81, Fila8=0xFF
    fila[0] = 8'h81;
    fila[7] = 8'hFF;
    push_frame(fila);
    d0 = done_cnt;
    pulse_start();
    chk("busy after start", {31'd0, busy}, 32'd1);
    time_frame(-1, n);
    chk("frame length", n, FRAME);
    chk("busy low at done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done one clock", {31'd0, done}, 32'd0);
    chk("one done per frame", done_cnt - d0, 1);

    // Snapshot isolation and ignored mid-frame start
    push_frame(fila);
    d0 = done_cnt;
    pulse_start();
    n = 0;
    while (cs && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    fila[2] = 8'h3C;
    repeat (4 * WORD) @(posedge clk);
    pulse_start();
    wait_idle(FRAME);
    repeat (150) @(posedge clk);
    #1;
    chk("no extra frame busy", {31'd0, busy}, 32'd0);
    chk("single done mid-start", done_cnt - d0, 1);
    push_frame(fila);
    pulse_start();
    time_frame(-1, n);
    chk("frame length updated rows", n, FRAME);

    // Start held high: back-to-back frames
    for (int i = 0; i < 8; i++) fila[i] = 8'(8'h11 * (i + 1));
    push_frame(fila);
    push_frame(fila);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    time_frame(-1, n);
    chk("held frame 1 length", n, FRAME);
    chk("idle clock between frames", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("restart after one idle", {31'd0, busy}, 32'd1);
    time_frame(100, n);
    chk("held frame 2 length", n, FRAME);
    wait_idle(20);

    // Reset during bit 9 of word 4
    push_frame(fila);
    pulse_start();
    falls = 0;
    pcs = cs;
    n = 0;
    while (falls < 4 && n < FRAME) begin
      @(negedge clk);
      if (pcs && !cs) falls++;
      pcs = cs;
      n++;
    end
    chk("reached word 4", falls, 4);
    falls = 0;
    pcs = sclk;
    n = 0;
    while (falls < 9 && n < WORD) begin
      @(negedge clk);
      if (sclk && !pcs) falls++;
      pcs = sclk;
      n++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort cs",   {31'd0, cs},   32'd1);
      chk("abort sclk", {31'd0, sclk}, 32'd0);
      chk("abort din",  {31'd0, din},  32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
    end
    d0 = done_cnt;
    after_reset_release();
    chk("no done after abort", done_cnt - d0, 0);

    repeat (20) @(posedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
